// File: rtl/mips16_mc_control.sv
// mips16_mc_control
// Multi-cycle main control FSM for the mips16 core. Sequences the shared ALU,
// the single memory port, the PC and the register file, waits on mem_ready
// for memory accesses, halts on an illegal opcode and counts retired
// instructions.

module mips16_mc_control #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       Opcode,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_LW    = 4'b0001;
  localparam logic [3:0] OP_SW    = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b0011;
  localparam logic [3:0] OP_SLTI  = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0101;
  localparam logic [3:0] OP_J     = 4'b0110;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEXE  = 4'd6,
    S_RTWB   = 4'd7,
    S_IEXE   = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t           r_state;
  logic [3:0]       r_opcode;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_retire;

  assign instr_count = r_instr_count;

  // Retirement: the last cycle of an instruction, i.e. the one that returns to FETCH
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_MEMWB, S_RTWB, S_IWB, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_MEMWR:                                  w_retire = mem_ready;
      default:                                  w_retire = 1'b0;
    endcase
  end

  // State sequencing, opcode latch (captured in DECODE) and retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_FETCH;
      r_opcode      <= 4'd0;
      r_instr_count <= '0;
    end else begin
      if (w_retire) begin
        r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      case (r_state)
        S_FETCH: begin
          if (mem_ready) r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_opcode <= Opcode;
          case (Opcode)
            OP_RTYPE:        r_state <= S_RTEXE;
            OP_LW, OP_SW:    r_state <= S_MEMADR;
            OP_ADDI, OP_SLTI: r_state <= S_IEXE;
            OP_BEQ:          r_state <= S_BRANCH;
            OP_J:            r_state <= S_JUMP;
            default:         r_state <= S_HALT;
          endcase
        end
        S_MEMADR: r_state <= (r_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (mem_ready) r_state <= S_MEMWB;
        end
        S_MEMWB:  r_state <= S_FETCH;
        S_MEMWR: begin
          if (mem_ready) r_state <= S_FETCH;
        end
        S_RTEXE:  r_state <= S_RTWB;
        S_RTWB:   r_state <= S_FETCH;
        S_IEXE:   r_state <= S_IWB;
        S_IWB:    r_state <= S_FETCH;
        S_BRANCH: r_state <= S_FETCH;
        S_JUMP:   r_state <= S_FETCH;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_HALT;
      endcase
    end
  end

  // Moore output decode; FETCH and BRANCH gate their PC/IR loads with mem_ready/Zero; all low in reset
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;
    halted   = 1'b0;
    if (rst) begin
      MemRead = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b11;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          ALUOp   = 2'b11;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
        end
        S_MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        S_RTEXE: begin
          ALUSrcA = 1'b1;
        end
        S_RTWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        S_IEXE: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          if (r_opcode == OP_SLTI) begin
            ALUOp = 2'b10;
          end else begin
            ALUOp = 2'b11;
          end
        end
        S_IWB: begin
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          PCSource = 2'b01;
          PCWrite  = Zero;
        end
        S_JUMP: begin
          PCSource = 2'b10;
          PCWrite  = 1'b1;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips16_mc_control.sv
// Self-checking bench for mips16_mc_control: directed scenarios followed by a
// random instruction stream with random wait states, each cycle compared
// against a per-instruction reference schedule built in the bench.

module tb_mips16_mc_control;

  localparam int CNT_W = 4;
  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       Opcode;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst;
  logic             MemtoReg, RegWrite, ALUSrcA, halted;
  logic [1:0]       ALUSrcB, ALUOp, PCSource;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;

  logic [15:0] obs_cw;

  mips16_mc_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign obs_cw = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
                   RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, halted};

  // Control word in the same field order as obs_cw:
  // PCWrite IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA ALUSrcB ALUOp PCSource halted
  function automatic logic [15:0] cw(input logic pcw, input logic iord, input logic mrd,
                                     input logic mwr, input logic irw, input logic rdst,
                                     input logic m2r, input logic rw, input logic asa,
                                     input logic [1:0] asb, input logic [1:0] aop,
                                     input logic [1:0] pcs, input logic hlt);
    return {pcw, iord, mrd, mwr, irw, rdst, m2r, rw, asa, asb, aop, pcs, hlt};
  endfunction

  function automatic logic [3:0] r4();
    return 4'($urandom_range(15, 0));
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic check_now(input string tag, input logic [15:0] exp);
    int m;
    logic [CNT_W-1:0] exp_cnt;
    m = model_cnt % (1 << CNT_W);
    exp_cnt = m[CNT_W-1:0];
    checks++;
    assert (obs_cw === exp) else begin
      errors++;
      $error("FAIL %s: control observed %b expected %b", tag, obs_cw, exp);
    end
    checks++;
    assert (instr_count === exp_cnt) else begin
      errors++;
      $error("FAIL %s: instr_count observed %0d expected %0d", tag, instr_count, exp_cnt);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check shortly after
  task automatic step(input string tag, input logic [3:0] op, input logic rdy,
                      input logic z, input logic [15:0] exp);
    @(negedge clk);
    Opcode    = op;
    mem_ready = rdy;
    Zero      = z;
    #1;
    check_now(tag, exp);
  endtask

  // Full instruction: fw fetch waits, mw memory waits, z = branch condition
  task automatic do_instr(input logic [3:0] op, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++)
      step("fetch_wait", r4(), L, rb(), cw(L,L,H,L,L,L,L,L,L,2'b01,2'b11,2'b00,L));
    step("fetch", r4(), H, rb(), cw(H,L,H,L,H,L,L,L,L,2'b01,2'b11,2'b00,L));
    step("decode", op, rb(), rb(), cw(L,L,L,L,L,L,L,L,L,2'b11,2'b11,2'b00,L));
    case (op)
      4'd0: begin
        step("rtexe", r4(), rb(), rb(), cw(L,L,L,L,L,L,L,L,H,2'b00,2'b00,2'b00,L));
        step("rtwb",  r4(), rb(), rb(), cw(L,L,L,L,L,H,L,H,L,2'b00,2'b00,2'b00,L));
      end
      4'd1: begin
        step("memadr", r4(), rb(), rb(), cw(L,L,L,L,L,L,L,L,H,2'b10,2'b11,2'b00,L));
        for (int i = 0; i < mw; i++)
          step("memrd_wait", r4(), L, rb(), cw(L,H,H,L,L,L,L,L,L,2'b00,2'b00,2'b00,L));
        step("memrd", r4(), H, rb(), cw(L,H,H,L,L,L,L,L,L,2'b00,2'b00,2'b00,L));
        step("memwb", r4(), rb(), rb(), cw(L,L,L,L,L,L,H,H,L,2'b00,2'b00,2'b00,L));
      end
      4'd2: begin
        step("memadr", r4(), rb(), rb(), cw(L,L,L,L,L,L,L,L,H,2'b10,2'b11,2'b00,L));
        for (int i = 0; i < mw; i++)
          step("memwr_wait", r4(), L, rb(), cw(L,H,L,H,L,L,L,L,L,2'b00,2'b00,2'b00,L));
        step("memwr", r4(), H, rb(), cw(L,H,L,H,L,L,L,L,L,2'b00,2'b00,2'b00,L));
      end
      4'd3, 4'd4: begin
        step("iexe", r4(), rb(), rb(),
             cw(L,L,L,L,L,L,L,L,H,2'b10,(op == 4'd4) ? 2'b10 : 2'b11,2'b00,L));
        step("iwb", r4(), rb(), rb(), cw(L,L,L,L,L,L,L,H,L,2'b00,2'b00,2'b00,L));
      end
      4'd5: step("branch", r4(), rb(), z, cw(z,L,L,L,L,L,L,L,H,2'b00,2'b01,2'b01,L));
      4'd6: step("jump", r4(), rb(), rb(), cw(H,L,L,L,L,L,L,L,L,2'b00,2'b00,2'b10,L));
      default: step("unexpected_op", r4(), L, L, 16'd0);
    endcase
    model_cnt++;
  endtask

  // Assert rst in the middle of a cycle, check its immediate effect, release after an edge
  task automatic reset_mid(input string tag);
    #1 rst = 1'b1;
    #1;
    model_cnt = 0;
    check_now({tag, "_async"}, 16'd0);
    @(posedge clk);
    #1;
    check_now({tag, "_held"}, 16'd0);
    mem_ready = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    Opcode    = 4'd0;
    Zero      = 1'b0;
    mem_ready = 1'b1;

    // Reset state: every output low, including MemRead/ALUOp of the FETCH state
    @(negedge clk);
    #1;
    check_now("reset", 16'd0);
    @(posedge clk);
    #1;
    check_now("reset_held", 16'd0);
    rst = 1'b0;

    // R-type at zero wait
    do_instr(4'd0, 0, 0, L);
    // lw with two wait cycles in MEMRD
    do_instr(4'd1, 0, 2, L);
    // beq taken, then not taken
    do_instr(4'd5, 0, 0, H);
    do_instr(4'd5, 1, 0, L);
    // slti then addi
    do_instr(4'd4, 0, 0, L);
    do_instr(4'd3, 2, 0, L);
    // sw with waits
    do_instr(4'd2, 1, 2, L);

    // Counter wrap: 16 jumps from zero
    reset_mid("rst_before_wrap");
    for (int i = 0; i < 16; i++) do_instr(4'd6, 0, 0, L);
    step("wrap_fetch", r4(), L, rb(), cw(L,L,H,L,L,L,L,L,L,2'b01,2'b11,2'b00,L));

    // Random instruction stream
    for (int n = 0; n < 60; n++)
      do_instr(4'($urandom_range(6, 0)), $urandom_range(2, 0), $urandom_range(2, 0), rb());

    // Reset during MEMWR aborts the store at once
    step("sw_fetch", r4(), H, rb(), cw(H,L,H,L,H,L,L,L,L,2'b01,2'b11,2'b00,L));
    step("sw_decode", 4'd2, rb(), rb(), cw(L,L,L,L,L,L,L,L,L,2'b11,2'b11,2'b00,L));
    step("sw_memadr", r4(), rb(), rb(), cw(L,L,L,L,L,L,L,L,H,2'b10,2'b11,2'b00,L));
    step("sw_memwr_wait", r4(), L, rb(), cw(L,H,L,H,L,L,L,L,L,2'b00,2'b00,2'b00,L));
    reset_mid("rst_in_memwr");

    // Illegal opcode: a couple of instructions, then HALT for 20 cycles
    do_instr(4'd0, 0, 0, L);
    do_instr(4'd6, 0, 0, L);
    step("ill_fetch", r4(), H, rb(), cw(H,L,H,L,H,L,L,L,L,2'b01,2'b11,2'b00,L));
    step("ill_decode", 4'b1010, rb(), rb(), cw(L,L,L,L,L,L,L,L,L,2'b11,2'b11,2'b00,L));
    for (int i = 0; i < 20; i++)
      step("halt", r4(), rb(), rb(), cw(L,L,L,L,L,L,L,L,L,2'b00,2'b00,2'b00,H));
    reset_mid("rst_in_halt");

    // Normal operation resumes after reset
    do_instr(4'd3, 0, 0, L);
    step("post_halt_fetch", r4(), L, rb(), cw(L,L,H,L,L,L,L,L,L,2'b01,2'b11,2'b00,L));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips16_mc_control.md
# mips16_mc_control

Multi-cycle main control FSM for the mips16 core. It sequences the shared ALU, the instruction/data memory port, the PC and the register file over 3–5 cycles per instruction. It drives the 2-bit `ALUOp` consumed by `alu_control`, plus every datapath mux and write enable. It also handles memory wait states through a ready handshake, halts on an illegal opcode, and counts retired instructions.

## Interface
Parameters:
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1: single system clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `Opcode`  in  4: instruction bits [15:12], taken from the instruction register.
- `Zero`  in  1: ALU zero flag, valid in the cycle it is used.
- `mem_ready`  in  1: memory completes the current access this cycle.
- `PCWrite`  out  1: load the PC.
- `IorD`  out  1: memory address select; 0 = PC, 1 = ALUOut.
- `MemRead`  out  1: memory read request.
- `MemWrite`  out  1: memory write request.
- `IRWrite`  out  1: load the instruction register.
- `RegDst`  out  1: register write address select; 0 = rt, 1 = rd.
- `MemtoReg`  out  1: register write data select; 0 = ALUOut, 1 = MDR.
- `RegWrite`  out  1: register file write enable.
- `ALUSrcA`  out  1: ALU A select; 0 = PC, 1 = register A.
- `ALUSrcB`  out  2: ALU B select; 00 = register B, 01 = constant 1, 10 = sign-extended imm, 11 = sign-extended imm (branch offset).
- `ALUOp`  out  2: 00 = R-type (decode funct), 01 = SUB, 10 = SLT, 11 = ADD.
- `PCSource`  out  2: PC input select; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `halted`  out  1: sticky illegal-opcode flag.
- `instr_count`  out  CNT_W: number of retired instructions.

## Operation
- Opcode map: 0000 R-type, 0001 lw, 0010 sw, 0011 addi, 0100 slti, 0101 beq, 0110 j. Opcodes 0111–1111 are illegal.
- Outputs are a Moore decode of the state register, with three exceptions gated as noted below. Every output not listed for a state is 0.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOp`=11, `PCSource`=00.
  - `IRWrite` and `PCWrite` equal `mem_ready`.
  - Go to DECODE when `mem_ready`=1, otherwise stay.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOp`=11 (branch target into ALUOut). Next state by opcode:
  - R-type → RTEXE
  - lw, sw → MEMADR
  - addi, slti → IEXE
  - beq → BRANCH
  - j → JUMP
  - illegal → HALT
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `ALUOp`=11. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead`=1, `IorD`=1. Go to MEMWB on `mem_ready`, otherwise stay.
- MEMWB: `RegWrite`=1, `MemtoReg`=1, `RegDst`=0. Go to FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Go to FETCH on `mem_ready`, otherwise stay.
- RTEXE: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=00. Go to RTWB.
- RTWB: `RegWrite`=1, `RegDst`=1, `MemtoReg`=0. Go to FETCH.
- IEXE: `ALUSrcA`=1, `ALUSrcB`=10. `ALUOp`=11 for addi, 10 for slti. Go to IWB.
  - The opcode is latched in DECODE; the `Opcode` input is not re-read.
- IWB: `RegWrite`=1, `RegDst`=0, `MemtoReg`=0. Go to FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, `ALUOp`=01, `PCSource`=01, `PCWrite`=`Zero`. Go to FETCH.
- JUMP: `PCSource`=10, `PCWrite`=1. Go to FETCH.
- HALT: all enables 0, `halted`=1. Stays in HALT until `rst`.
- `instr_count` increments by 1 on every transition into FETCH from MEMWB, MEMWR, RTWB, IWB, BRANCH or JUMP.
  - It wraps from 2^CNT_W−1 to 0.
  - A not-taken beq still counts as retired.

## Timing
- Reset, asynchronous: state = FETCH, `instr_count` = 0, `halted` = 0.
  - While `rst`=1 all outputs are forced to 0, including `MemRead` and `ALUOp`.
  - The first FETCH is issued in the first cycle after `rst` falls.
- Reset asserted mid-instruction aborts it immediately. No partial write is issued after the asserting edge.
- Memory handshake: an access completes in the cycle where the request (`MemRead` or `MemWrite`) and `mem_ready` are both 1. Requests hold steady while `mem_ready`=0, with no timeout.
- `mem_ready`=1 outside FETCH, MEMRD and MEMWR is ignored.
- Cycles per instruction at zero wait: R-type 4, lw 5, sw 4, addi/slti 4, beq 3, j 3. Each wait cycle in FETCH, MEMRD or MEMWR adds 1.
- `Zero` is sampled combinationally in BRANCH only.

## Test plan
- Reset then `mem_ready`=1 constantly with R-type (0000): state sequence FETCH, DECODE, RTEXE, RTWB, FETCH; `RegWrite`=1 and `RegDst`=1 only in cycle 4; `ALUOp`=00 in cycle 3; `instr_count`=1 after 4 cycles.
- lw with `mem_ready` low for 2 cycles in MEMRD: `MemRead`=1 and `IorD`=1 held 3 cycles; MEMWB has `MemtoReg`=1; total 7 cycles; `instr_count` +1.
- beq with `Zero`=1, then beq with `Zero`=0: `PCWrite`=1 with `PCSource`=01 in the first BRANCH and `PCWrite`=0 in the second; each takes 3 cycles; count +2.
- slti then addi: IEXE `ALUOp`=10, then 11; `ALUSrcB`=10; `RegDst`=0 in IWB.
- Opcode 1010 in DECODE: HALT next cycle, `halted`=1 and all enables 0 for 20 cycles; `instr_count` frozen. Async `rst` mid-cycle clears `halted` and `instr_count` without waiting for a clock edge.
- With CNT_W=4, run 16 back-to-back j instructions: `instr_count` reaches 15, then wraps to 0; `rst` asserted during MEMWR: `MemWrite` drops to 0 immediately.
